// File: rtl/speaker_pcm_decimator_if.sv
// Sample stream from speaker_pcm_decimator to the audio mixer.
// valid/ready: a sample transfers on every rising clk_logic edge where sample_valid_o && sample_ready_i;
// once sample_valid_o is high, sample_o holds steady and valid stays high until that transfer.
interface speaker_pcm_decimator_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic [SAMPLE_WIDTH-1:0] sample_o;
    logic                    sample_valid_o;
    logic                    sample_ready_i;

    modport master (output sample_o, output sample_valid_o, input sample_ready_i);
    modport slave  (input sample_o, input sample_valid_o, output sample_ready_i);
endinterface

// File: rtl/speaker_pcm_decimator.sv
// Box-car decimates the 1-bit speaker level into a signed PCM sample per strobe-delimited window.
// Optional DC blocker enabled by defining SPEAKER_DC_BLOCK_EN.
module speaker_pcm_decimator #(
    parameter int COUNT_WIDTH  = 12,
    parameter int SAMPLE_WIDTH = 16,
    parameter int DC_SHIFT     = 4
) (
    input  logic                    clk_logic,
    input  logic                    system_reset_n,
    input  logic                    speaker_i,
    input  logic                    sample_strobe_i,
    speaker_pcm_decimator_if.master pcm,
    output logic                    overrun_o,
    input  logic                    overrun_clr_i,
    output logic [1:0]              state_dbg
);
    localparam int CW    = COUNT_WIDTH;
    localparam int SW    = SAMPLE_WIDTH;
    localparam int QW    = SAMPLE_WIDTH - 1;
    localparam int CNT_W = $clog2(SAMPLE_WIDTH);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, DIV, FILT, OUT} state_t;

    if (DC_SHIFT < 1 || DC_SHIFT > SAMPLE_WIDTH) begin : g_bad_dc_shift
        $error("speaker_pcm_decimator: DC_SHIFT out of range");
    end

    state_t          state;
    logic [CW-1:0]   tot, hi, tot_nx, hi_nx;
    logic [CW-1:0]   divisor;
    logic [CW:0]     rem, rem_shift, rem_sub;
    logic            rem_ge;
    logic [QW-1:0]   quo, frac;
    logic            q_int;
    logic [CNT_W-1:0] bit_cnt;
    logic [SW-1:0]   y;

    assign state_dbg = state;

    // Saturating window counts including the current cycle.
    assign tot_nx = (tot == CNT_MAX) ? tot : tot + 1'b1;
    assign hi_nx  = (speaker_i && (hi != CNT_MAX)) ? hi + 1'b1 : hi;

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            tot <= '0;
            hi  <= '0;
        end else if (sample_strobe_i) begin
            tot <= '0;
            hi  <= '0;
        end else begin
            tot <= tot_nx;
            hi  <= hi_nx;
        end
    end

    // Restoring division of hi*2^QW by tot: the integer part (only 0 or 1 since hi<=tot)
    // is resolved at capture, the QW fraction bits are produced one per DIV cycle.
    assign rem_shift = rem << 1;
    assign rem_sub   = rem_shift - {1'b0, divisor};
    assign rem_ge    = (rem_shift >= {1'b0, divisor});
    assign frac      = q_int ? {QW{1'b1}} : quo;

`ifdef SPEAKER_DC_BLOCK_EN
    localparam logic signed [SW+1:0] Y_MAX = (SW+2)'((2 ** (SW - 1)) - 1);
    localparam logic signed [SW+1:0] Y_MIN = -(SW+2)'(2 ** (SW - 1));

    logic signed [SW:0]   dc;
    logic signed [SW+1:0] diff, dc_next;

    assign diff    = $signed({3'b000, frac}) - $signed({dc[SW], dc});
    assign dc_next = $signed({dc[SW], dc}) + (diff >>> DC_SHIFT);

    always_comb begin
        y = diff[SW-1:0];
        if (diff > Y_MAX)      y = Y_MAX[SW-1:0];
        else if (diff < Y_MIN) y = Y_MIN[SW-1:0];
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n)    dc <= '0;
        else if (state == FILT) dc <= dc_next[SW:0];
    end
`else
    assign y = {1'b0, frac};
`endif

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state              <= IDLE;
            pcm.sample_o       <= '0;
            pcm.sample_valid_o <= 1'b0;
            overrun_o          <= 1'b0;
            divisor            <= '0;
            rem                <= '0;
            quo                <= '0;
            q_int              <= 1'b0;
            bit_cnt            <= '0;
        end else begin
            if (sample_strobe_i && (state != IDLE)) overrun_o <= 1'b1;
            else if (overrun_clr_i)                 overrun_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (sample_strobe_i) begin
                        divisor <= tot_nx;
                        q_int   <= (hi_nx == tot_nx);
                        rem     <= (hi_nx == tot_nx) ? '0 : {1'b0, hi_nx};
                        quo     <= '0;
                        bit_cnt <= CNT_W'(QW - 1);
                        state   <= DIV;
                    end
                end
                DIV: begin
                    rem <= rem_ge ? rem_sub : rem_shift;
                    quo <= {quo[QW-2:0], rem_ge};
                    if (bit_cnt == '0) state <= FILT;
                    else               bit_cnt <= bit_cnt - 1'b1;
                end
                FILT: begin
                    pcm.sample_o       <= y;
                    pcm.sample_valid_o <= 1'b1;
                    state              <= OUT;
                end
                OUT: begin
                    if (pcm.sample_ready_i) begin
                        pcm.sample_valid_o <= 1'b0;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_speaker_pcm_decimator.sv
// Randomized bench for speaker_pcm_decimator against a window-level reference model.
// Define SPEAKER_DC_BLOCK_EN for both the bench and the RTL to cover the DC blocker.
module tb_speaker_pcm_decimator;
    localparam int SW       = 16;
    localparam int CNT_MAX  = 4095;
    localparam int Q_MAX    = 32767;
    localparam int DC_SHIFT = 4;
    localparam int LATENCY  = 17;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic spk = 1'b0, stb = 1'b0, rdy = 1'b0, clr = 1'b0;
    logic overrun;
    logic [1:0] state_dbg;

    speaker_pcm_decimator_if #(.SAMPLE_WIDTH(SW)) pcm_if ();
    assign pcm_if.sample_ready_i = rdy;

    speaker_pcm_decimator dut (
        .clk_logic       (clk),
        .system_reset_n  (rst_n),
        .speaker_i       (spk),
        .sample_strobe_i (stb),
        .pcm             (pcm_if.master),
        .overrun_o       (overrun),
        .overrun_clr_i   (clr),
        .state_dbg       (state_dbg)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-window counts, expected samples, and cycles until the result appears.
    logic [SW-1:0] exp_q[$];
    int m_hi = 0, m_tot = 0, m_cd = 0, m_dc = 0;
    bit m_busy = 0, m_valid = 0, m_ovr = 0;

    function automatic int sat_cnt(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic model_window(input int h, input int t);
        longint q;
        int frac, y;
        q    = (longint'(h) * 32768) / t;
        frac = (q > Q_MAX) ? Q_MAX : int'(q);
`ifdef SPEAKER_DC_BLOCK_EN
        begin
            int d;
            d = frac - m_dc;
            y = (d > 32767) ? 32767 : (d < -32768) ? -32768 : d;
            m_dc = m_dc + (d >>> DC_SHIFT);
        end
`else
        y = frac;
`endif
        exp_q.push_back(y[SW-1:0]);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_hi = 0; m_tot = 0; m_cd = 0; m_dc = 0;
            m_busy = 0; m_valid = 0; m_ovr = 0;
            exp_q.delete();
            check_val("rst_valid", 32'(pcm_if.sample_valid_o), 0);
            check_val("rst_sample", 32'(pcm_if.sample_o), 0);
            check_val("rst_overrun", 32'(overrun), 0);
        end else begin
            bit hs, ovr_set;
            check_val("valid", 32'(pcm_if.sample_valid_o), 32'(m_valid));
            if (m_valid && exp_q.size() > 0)
                check_val("sample", 32'($signed(pcm_if.sample_o)), 32'($signed(exp_q[0])));
            check_val("overrun", 32'(overrun), 32'(m_ovr));

            hs      = m_valid && rdy;
            ovr_set = 0;
            if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) m_valid = 1;
            end
            if (stb) begin
                if (!m_busy) begin
                    model_window(sat_cnt(m_hi + int'(spk)), sat_cnt(m_tot + 1));
                    m_busy = 1;
                    m_cd   = LATENCY - 1;
                end else begin
                    ovr_set = 1;
                end
                m_hi = 0; m_tot = 0;
            end else begin
                m_hi  = sat_cnt(m_hi + int'(spk));
                m_tot = sat_cnt(m_tot + 1);
            end
            if (hs) begin
                m_valid = 0;
                m_busy  = 0;
                void'(exp_q.pop_front());
            end
            if (ovr_set)  m_ovr = 1;
            else if (clr) m_ovr = 0;
        end
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic drive(input logic s, input logic st, input logic r, input logic c);
        spk = s; stb = st; rdy = r; clr = c;
        @(posedge clk);
        #1;
    endtask

    // mode 0: speaker high for the first hi_n cycles; mode 1: random speaker.
    // rmode 0: ready high; 1: random ready and clear; 2: ready low.
    task automatic window(input int len, input int mode, input int hi_n, input int rmode);
        for (int i = 0; i < len; i++) begin
            logic s, r, c;
            s = (mode == 1) ? logic'($urandom_range(0, 1)) : logic'(i < hi_n);
            r = (rmode == 0) ? 1'b1 : (rmode == 1) ? logic'($urandom_range(0, 1)) : 1'b0;
            c = (rmode == 1) ? logic'($urandom_range(0, 15) == 0) : 1'b0;
            drive(s, logic'(i == len - 1), r, c);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (2) window(100, 0, 0, 0);
        repeat (3) window(100, 0, 100, 0);
        repeat (2) window(100, 0, 25, 0);

        for (int k = 0; k < 30; k++)
            window($urandom_range(3, 300), 1, 0, $urandom_range(0, 1));
        repeat (2) window(100, 0, 0, 0);

        // back-pressure and overruns with a held sample
        window(100, 0, 50, 2);
        window(5, 0, 0, 2);
        window(40, 0, 0, 2);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b1);
        window(100, 0, 10, 0);

        // saturating windows longer than the counter range
        window(5000, 0, 5000, 0);
        window(5000, 1, 0, 0);
        window(100, 0, 30, 0);

        // reset in the middle of the division
        window(100, 0, 70, 0);
        repeat (5) drive(1'b1, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(pcm_if.sample_valid_o), 0);
        check_val("async_rst_sample", 32'(pcm_if.sample_o), 0);
        check_val("async_rst_overrun", 32'(overrun), 0);
        check_val("async_rst_state", 32'(state_dbg), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        window(100, 0, 60, 0);
        window(100, 0, 75, 0);
        repeat (30) drive(1'b0, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
